pc_ctrl: RTL and testbench

Next-PC controller for the single-cycle core. It sits in front of `pc_reg` and drives that block's `jump_en_i`/`jump_addr_i`. It sequences boot hold-off, arbitrates the competing redirect sources (trap, mret, branch, jal, interrupt), and freezes the PC during stalls by reloading the current PC. It also buffers a redirect that arrives while stalled and keeps the exception PC, cause and interrupt enable.

---
 rtl/pc_ctrl_pkg.sv | 31 +++
 rtl/pc_ctrl_redirect_sel.sv | 71 +++++++
 rtl/pc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pc_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared encodings for the next-PC controller: FSM states, cause codes, source ranks.
package pc_ctrl_pkg;

  localparam int CpuWidth = 32;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_TRAP     = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_IRQ      = 2'd3;

  // Larger rank wins; used to decide whether a new source may displace a pending one.
  localparam logic [2:0] RANK_NONE     = 3'd0;
  localparam logic [2:0] RANK_IRQ      = 3'd1;
  localparam logic [2:0] RANK_JAL      = 3'd2;
  localparam logic [2:0] RANK_BRANCH   = 3'd3;
  localparam logic [2:0] RANK_MRET     = 3'd4;
  localparam logic [2:0] RANK_MISALIGN = 3'd5;
  localparam logic [2:0] RANK_TRAP     = 3'd6;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_ctrl_redirect_sel.sv
// Combinational priority select over the redirect sources; returns target,
// rank and the epc/cause/ie values the winning source would commit.
module pc_redirect_sel
  import pc_ctrl_pkg::*;
#(
  parameter int               WIDTH    = CpuWidth,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(DEF_TRAP_VEC)
) (
  input  logic             trap_i,
  input  logic             mret_i,
  input  logic             branch_en_i,
  input  logic [WIDTH-1:0] branch_addr_i,
  input  logic             jal_en_i,
  input  logic [WIDTH-1:0] jal_addr_i,
  input  logic             irq_i,
  input  logic             irq_ok_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] epc_i,
  input  logic [1:0]       cause_i,
  input  logic             ie_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] target_o,
  output logic [2:0]       rank_o,
  output logic [WIDTH-1:0] epc_o,
  output logic [1:0]       cause_o,
  output logic             ie_o,
  output logic             misalign_o
);

  logic [WIDTH-1:0] xfer_tgt;

  always_comb begin
    xfer_tgt   = branch_en_i ? branch_addr_i : jal_addr_i;
    misalign_o = (branch_en_i | jal_en_i) & is_misaligned(xfer_tgt[1:0]);
    valid_o    = 1'b1;
    target_o   = TRAP_VEC;
    rank_o     = RANK_NONE;
    epc_o      = epc_i;
    cause_o    = cause_i;
    ie_o       = ie_i;
    if (trap_i) begin
      rank_o  = RANK_TRAP;
      epc_o   = pc_i;
      cause_o = CAUSE_TRAP;
      ie_o    = 1'b0;
    end else if (misalign_o) begin
      rank_o  = RANK_MISALIGN;
      epc_o   = pc_i;
      cause_o = CAUSE_MISALIGN;
      ie_o    = 1'b0;
    end else if (mret_i) begin
      rank_o   = RANK_MRET;
      target_o = epc_i;
      ie_o     = 1'b1;
    end else if (branch_en_i) begin
      rank_o   = RANK_BRANCH;
      target_o = branch_addr_i;
    end else if (jal_en_i) begin
      rank_o   = RANK_JAL;
      target_o = jal_addr_i;
    end else if (irq_i && ie_i && irq_ok_i) begin
      rank_o  = RANK_IRQ;
      epc_o   = pc_i + WIDTH'(4);
      cause_o = CAUSE_IRQ;
      ie_o    = 1'b0;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Next-PC controller: boot hold-off, redirect arbitration, stall freeze with a
// one-entry pending redirect, and the epc/cause/ie trap state.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int               WIDTH       = CpuWidth,
  parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC    = WIDTH'(DEF_TRAP_VEC),
  parameter int               BOOT_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic             stall_i,
  input  logic             branch_en_i,
  input  logic [WIDTH-1:0] branch_addr_i,
  input  logic             jal_en_i,
  input  logic [WIDTH-1:0] jal_addr_i,
  input  logic             trap_i,
  input  logic             mret_i,
  input  logic             irq_i,
  output logic             jump_en_o,
  output logic [WIDTH-1:0] jump_addr_o,
  output logic             flush_o,
  output logic [WIDTH-1:0] epc_o,
  output logic [1:0]       cause_o,
  output logic             ie_o,
  output logic             busy_o
);

  localparam int CW = $clog2(BOOT_CYCLES + 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic             ie_q, ie_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [WIDTH-1:0] pend_epc_q, pend_epc_d;
  logic [1:0]       pend_cause_q, pend_cause_d;
  logic             pend_ie_q, pend_ie_d;
  logic [2:0]       pend_rank_q, pend_rank_d;

  logic             sel_vld;
  logic [WIDTH-1:0] sel_tgt;
  logic [2:0]       sel_rank;
  logic [WIDTH-1:0] sel_epc;
  logic [1:0]       sel_cause;
  logic             sel_ie;
  logic             unused_sel_misalign;

  pc_redirect_sel #(
    .WIDTH    (WIDTH),
    .TRAP_VEC (TRAP_VEC)
  ) u_sel (
    .trap_i        (trap_i),
    .mret_i        (mret_i),
    .branch_en_i   (branch_en_i),
    .branch_addr_i (branch_addr_i),
    .jal_en_i      (jal_en_i),
    .jal_addr_i    (jal_addr_i),
    .irq_i         (irq_i),
    .irq_ok_i      (!stall_i),
    .pc_i          (pc_i),
    .epc_i         (epc_q),
    .cause_i       (cause_q),
    .ie_i          (ie_q),
    .valid_o       (sel_vld),
    .target_o      (sel_tgt),
    .rank_o        (sel_rank),
    .epc_o         (sel_epc),
    .cause_o       (sel_cause),
    .ie_o          (sel_ie),
    .misalign_o    (unused_sel_misalign)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    ie_d         = ie_q;
    pend_tgt_d   = pend_tgt_q;
    pend_epc_d   = pend_epc_q;
    pend_cause_d = pend_cause_q;
    pend_ie_d    = pend_ie_q;
    pend_rank_d  = pend_rank_q;
    jump_en_o    = 1'b0;
    jump_addr_o  = pc_i;
    flush_o      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        jump_en_o   = 1'b1;
        jump_addr_o = RESET_VEC;
        if (cnt_q <= CW'(1)) state_d = ST_RUN;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      ST_HOLD: begin
        jump_en_o = 1'b1;
        if (stall_i) begin
          // Only a strictly more urgent source may displace the pending one.
          if (sel_vld && (sel_rank > pend_rank_q)) begin
            pend_tgt_d   = sel_tgt;
            pend_epc_d   = sel_epc;
            pend_cause_d = sel_cause;
            pend_ie_d    = sel_ie;
            pend_rank_d  = sel_rank;
          end
        end else begin
          jump_addr_o = pend_tgt_q;
          flush_o     = 1'b1;
          epc_d       = pend_epc_q;
          cause_d     = pend_cause_q;
          ie_d        = pend_ie_q;
          pend_rank_d = RANK_NONE;
          state_d     = ST_RUN;
        end
      end
      default: begin
        if (stall_i) begin
          jump_en_o = 1'b1;
          if (sel_vld) begin
            pend_tgt_d   = sel_tgt;
            pend_epc_d   = sel_epc;
            pend_cause_d = sel_cause;
            pend_ie_d    = sel_ie;
            pend_rank_d  = sel_rank;
            state_d      = ST_HOLD;
          end
        end else if (sel_vld) begin
          jump_en_o   = 1'b1;
          jump_addr_o = sel_tgt;
          flush_o     = 1'b1;
          epc_d       = sel_epc;
          cause_d     = sel_cause;
          ie_d        = sel_ie;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_BOOT;
      cnt_q        <= CW'(BOOT_CYCLES);
      epc_q        <= '0;
      cause_q      <= CAUSE_NONE;
      ie_q         <= 1'b1;
      pend_tgt_q   <= '0;
      pend_epc_q   <= '0;
      pend_cause_q <= CAUSE_NONE;
      pend_ie_q    <= 1'b0;
      pend_rank_q  <= RANK_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      ie_q         <= ie_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_epc_q   <= pend_epc_d;
      pend_cause_q <= pend_cause_d;
      pend_ie_q    <= pend_ie_d;
      pend_rank_q  <= pend_rank_d;
    end
  end

  assign epc_o   = epc_q;
  assign cause_o = cause_q;
  assign ie_o    = ie_q;
  assign busy_o  = (state_q == ST_BOOT);

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: a behavioural model predicts each cycle's outputs,
// a negedge monitor compares; directed test-plan cases plus randomized traffic.
module tb_pc_ctrl;

  localparam logic [31:0] RV   = 32'h0;
  localparam logic [31:0] TV   = 32'h100;
  localparam int          BOOT = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_q;
  logic        stall_i = 1'b0, branch_en_i = 1'b0, jal_en_i = 1'b0;
  logic        trap_i = 1'b0, mret_i = 1'b0, irq_i = 1'b0;
  logic [31:0] branch_addr_i = '0, jal_addr_i = '0;
  logic        jump_en_o, flush_o, ie_o, busy_o;
  logic [31:0] jump_addr_o, epc_o;
  logic [1:0]  cause_o;

  pc_ctrl #(.WIDTH(32), .RESET_VEC(RV), .TRAP_VEC(TV), .BOOT_CYCLES(BOOT)) dut (
    .clk_i(clk), .rst_i(rst_i), .pc_i(pc_q), .stall_i(stall_i),
    .branch_en_i(branch_en_i), .branch_addr_i(branch_addr_i),
    .jal_en_i(jal_en_i), .jal_addr_i(jal_addr_i),
    .trap_i(trap_i), .mret_i(mret_i), .irq_i(irq_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .flush_o(flush_o),
    .epc_o(epc_o), .cause_o(cause_o), .ie_o(ie_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Stand-in for pc_reg: load on jump, otherwise step by 4.
  always @(posedge clk or posedge rst_i)
    if (rst_i) pc_q <= RV;
    else       pc_q <= jump_en_o ? jump_addr_o : pc_q + 32'd4;

  typedef struct {
    bit          v;
    int          rank;
    logic [31:0] tgt;
    logic [31:0] epc;
    logic [1:0]  cause;
    bit          ie;
  } req_t;

  typedef struct {
    bit          jen;
    logic [31:0] addr;
    bit          flush;
    bit          busy;
    logic [31:0] epc;
    logic [1:0]  cause;
    bit          ie;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          boot_left;
  bit          pend_v;
  req_t        pend;
  logic [31:0] m_epc;
  logic [1:0]  m_cause;
  bit          m_ie;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic req_t mk(int rank, logic [31:0] tgt, logic [31:0] epc, logic [1:0] cause, bit ie);
    req_t r;
    r.v = 1'b1; r.rank = rank; r.tgt = tgt; r.epc = epc; r.cause = cause; r.ie = ie;
    return r;
  endfunction

  // Candidates listed in priority order; the first active one wins.
  function automatic req_t pick(bit trap, bit mret, bit br, logic [31:0] bra, bit jl,
                                logic [31:0] jla, bit irq, bit stalled);
    req_t        c[6];
    bit          act[6];
    req_t        none;
    logic [31:0] xt;
    xt     = br ? bra : jla;
    act    = '{trap, (br || jl) && (xt % 4 != 0), mret, br, jl, irq && m_ie && !stalled};
    c[0]   = mk(6, TV, pc_q, 2'd1, 1'b0);
    c[1]   = mk(5, TV, pc_q, 2'd2, 1'b0);
    c[2]   = mk(4, m_epc, m_epc, m_cause, 1'b1);
    c[3]   = mk(3, bra, m_epc, m_cause, m_ie);
    c[4]   = mk(2, jla, m_epc, m_cause, m_ie);
    c[5]   = mk(1, TV, pc_q + 32'd4, 2'd3, 1'b0);
    for (int i = 0; i < 6; i++) if (act[i]) return c[i];
    none   = mk(0, '0, '0, 2'd0, 1'b0);
    none.v = 1'b0;
    return none;
  endfunction

  task automatic cycle(bit rs, bit st, bit tr, bit mr, bit br, logic [31:0] bra,
                       bit jl, logic [31:0] jla, bit iq);
    exp_t        e;
    req_t        r;
    int          n_boot;
    bit          n_pv;
    req_t        n_pend;
    logic [31:0] n_epc;
    logic [1:0]  n_cause;
    bit          n_ie;
    rst_i = rs; stall_i = st; trap_i = tr; mret_i = mr;
    branch_en_i = br; branch_addr_i = bra; jal_en_i = jl; jal_addr_i = jla; irq_i = iq;
    if (rs) begin
      boot_left = BOOT; pend_v = 1'b0; m_epc = '0; m_cause = 2'd0; m_ie = 1'b1;
    end
    e.epc = m_epc; e.cause = m_cause; e.ie = m_ie;
    e.jen = 1'b0; e.addr = pc_q; e.flush = 1'b0; e.busy = 1'b0;
    n_boot = boot_left; n_pv = pend_v; n_pend = pend;
    n_epc = m_epc; n_cause = m_cause; n_ie = m_ie;
    if (rs) begin
      e.jen = 1'b1; e.addr = RV; e.busy = 1'b1;
    end else if (boot_left > 0) begin
      e.jen = 1'b1; e.addr = RV; e.busy = 1'b1;
      n_boot = boot_left - 1;
    end else if (st) begin
      e.jen = 1'b1; e.addr = pc_q;
      r = pick(tr, mr, br, bra, jl, jla, iq, 1'b1);
      if (r.v && (!pend_v || r.rank > pend.rank)) begin
        n_pend = r; n_pv = 1'b1;
      end
    end else if (pend_v) begin
      e.jen = 1'b1; e.addr = pend.tgt; e.flush = 1'b1;
      n_epc = pend.epc; n_cause = pend.cause; n_ie = pend.ie; n_pv = 1'b0;
    end else begin
      r = pick(tr, mr, br, bra, jl, jla, iq, 1'b0);
      if (r.v) begin
        e.jen = 1'b1; e.addr = r.tgt; e.flush = 1'b1;
        n_epc = r.epc; n_cause = r.cause; n_ie = r.ie;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    boot_left = n_boot; pend_v = n_pv; pend = n_pend;
    m_epc = n_epc; m_cause = n_cause; m_ie = n_ie;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, '0, 0, '0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("jump_en", 32'(jump_en_o), 32'(e.jen));
      if (e.jen) chk("jump_addr", jump_addr_o, e.addr);
      chk("flush", 32'(flush_o), 32'(e.flush));
      chk("busy", 32'(busy_o), 32'(e.busy));
      chk("epc", epc_o, e.epc);
      chk("cause", 32'(cause_o), 32'(e.cause));
      chk("ie", 32'(ie_o), 32'(e.ie));
    end
  end

  initial begin
    logic [31:0] ba, ja;
    pend = mk(0, '0, '0, 2'd0, 1'b0);
    pend.v = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0, '0, 0, '0, 0);
    idle(BOOT);
    chk("boot_pc_hold", pc_q, 32'h0);
    idle(1); chk("seq_pc4", pc_q, 32'h4);
    idle(1); chk("seq_pc8", pc_q, 32'h8);
    idle(1); chk("seq_pc12", pc_q, 32'hc);
    cycle(0, 0, 0, 0, 1, 32'h40, 1, 32'h80, 0);
    chk("branch_over_jal", pc_q, 32'h40);
    idle(1);
    cycle(0, 0, 0, 0, 0, '0, 1, 32'h10, 0);
    cycle(0, 1, 0, 0, 1, 32'h20, 0, '0, 0); chk("stall_hold1", pc_q, 32'h10);
    cycle(0, 1, 1, 0, 0, '0, 0, '0, 0);     chk("stall_hold2", pc_q, 32'h10);
    cycle(0, 1, 0, 0, 0, '0, 0, '0, 0);     chk("stall_hold3", pc_q, 32'h10);
    cycle(0, 0, 0, 0, 0, '0, 0, '0, 0);
    chk("release_pc", pc_q, 32'h100);
    chk("release_epc", epc_o, 32'h10);
    chk("release_cause", 32'(cause_o), 32'd1);
    chk("release_ie", 32'(ie_o), 32'd0);
    cycle(0, 0, 0, 1, 0, '0, 0, '0, 0);
    cycle(0, 0, 0, 0, 0, '0, 1, 32'h30, 0);
    cycle(0, 0, 0, 0, 0, '0, 0, '0, 1);
    chk("irq_pc", pc_q, 32'h100);
    chk("irq_epc", epc_o, 32'h34);
    chk("irq_cause", 32'(cause_o), 32'd3);
    cycle(0, 0, 0, 1, 0, '0, 0, '0, 0);
    chk("mret_pc", pc_q, 32'h34);
    chk("mret_ie", 32'(ie_o), 32'd1);
    cycle(0, 0, 0, 0, 1, 32'h8, 0, '0, 0);
    cycle(0, 0, 0, 0, 0, '0, 1, 32'h42, 0);
    chk("misalign_pc", pc_q, 32'h100);
    chk("misalign_epc", epc_o, 32'h8);
    chk("misalign_cause", 32'(cause_o), 32'd2);
    cycle(0, 1, 0, 0, 1, 32'h200, 0, '0, 0);
    cycle(1, 1, 0, 0, 0, '0, 0, '0, 0);
    chk("rst_hold_pc", pc_q, 32'h0);
    chk("rst_hold_ie", 32'(ie_o), 32'd1);
    chk("rst_hold_busy", 32'(busy_o), 32'd1);
    idle(BOOT);
    idle(1);
    chk("rst_drops_pending", pc_q, 32'h4);
    for (int i = 0; i < 2500; i++) begin
      ba = {22'($urandom_range(0, 4095)), 10'h0} | 32'($urandom_range(0, 255) * 4);
      ja = {22'($urandom_range(0, 4095)), 10'h0} | 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 7) == 0) ba = ba + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) ja = ja + 32'($urandom_range(1, 3));
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 15, ba, $urandom_range(0, 99) < 12, ja,
            $urandom_range(0, 99) < 20);
    end
    idle(2);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
